// File: rtl/instruction_loader.sv
// Boot-time loader: receives a framed byte stream (length, payload, checksum) and
// writes the payload as big-endian 32-bit words into instruction memory.
module instruction_loader #(
   parameter int          MEM_BYTES = 64,
   parameter int          MAX_WORDS = MEM_BYTES / 4,
   parameter logic [63:0] BASE_ADDR = 64'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        im_wr_en,
   output logic [63:0] im_wr_addr,
   output logic [31:0] im_wr_data,
   output logic        core_stall,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [4:0]  words_loaded
);

   localparam int         IDX_W   = $clog2(MAX_WORDS);
   localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   state_t             r_state;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;
   logic               r_error;
   logic               r_wr_en;
   logic [63:0]        r_wr_addr;
   logic [31:0]        r_wr_data;
   logic [4:0]         r_words;
   logic [23:0]        r_asm;
   logic [1:0]         r_byte_idx;
   logic [IDX_W-1:0]   r_word_idx;
   logic [IDX_W-1:0]   r_last_idx;
   logic [7:0]         r_csum;
   logic               w_xfer;

   assign w_xfer = in_valid && r_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= 64'd0;
         r_wr_data  <= 32'd0;
         r_words    <= 5'd0;
         r_asm      <= 24'd0;
         r_byte_idx <= 2'd0;
         r_word_idx <= '0;
         r_last_idx <= '0;
         r_csum     <= 8'd0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
                  r_words <= 5'd0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_LEN;
               end
            end
            S_LEN: begin
               if (w_xfer) begin
                  if (in_data == 8'd0 || in_data > MAX_LEN) begin
                     r_ready <= 1'b0;
                     r_busy  <= 1'b0;
                     r_error <= 1'b1;
                     r_state <= S_ERR;
                  end else begin
                     r_last_idx <= IDX_W'(in_data - 8'd1);
                     r_byte_idx <= 2'd0;
                     r_word_idx <= '0;
                     r_csum     <= 8'd0;
                     r_state    <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_csum     <= r_csum ^ in_data;
                  r_asm      <= {r_asm[15:0], in_data};
                  r_byte_idx <= r_byte_idx + 2'd1;
                  // Fourth byte completes the word straight into the output register.
                  if (r_byte_idx == 2'd3) begin
                     r_wr_en    <= 1'b1;
                     r_wr_addr  <= BASE_ADDR + 64'({r_word_idx, 2'b00});
                     r_wr_data  <= {r_asm, in_data};
                     r_words    <= r_words + 5'd1;
                     r_word_idx <= r_word_idx + IDX_W'(1);
                     if (r_word_idx == r_last_idx) begin
                        r_state <= S_CHECK;
                     end
                  end
               end
            end
            S_CHECK: begin
               if (w_xfer) begin
                  r_ready <= 1'b0;
                  r_busy  <= 1'b0;
                  if (in_data == r_csum) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_error <= 1'b1;
                     r_state <= S_ERR;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            S_ERR:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready     = r_ready;
   assign busy         = r_busy;
   assign core_stall   = r_busy;
   assign done         = r_done;
   assign error        = r_error;
   assign im_wr_en     = r_wr_en;
   assign im_wr_addr   = r_wr_addr;
   assign im_wr_data   = r_wr_data;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed and random frames checked against a
// frame-level reference model of expected writes and final status.
module tb_instruction_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready;
   logic        im_wr_en;
   logic [63:0] im_wr_addr;
   logic [31:0] im_wr_data;
   logic        core_stall;
   logic        busy;
   logic        done;
   logic        error;
   logic [4:0]  words_loaded;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  fr[$];
   logic [95:0] wq[$];

   instruction_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_wr_en     (im_wr_en),
      .im_wr_addr   (im_wr_addr),
      .im_wr_data   (im_wr_data),
      .core_stall   (core_stall),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (im_wr_en) wq.push_back({im_wr_addr, im_wr_data});
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered and left at a falling edge.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int cnt;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt == 20) check_val("ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_writes(input int nw, input int wlim);
      int k;
      check_val("wr_count", 64'(wq.size()), 64'(nw));
      for (k = 0; k < nw && k < wq.size() && k < wlim; k++) begin
         check_val($sformatf("wr_addr%0d", k), 64'(wq[k][95:32]), 64'(4 * k));
         check_val($sformatf("wr_data%0d", k), 64'(wq[k][31:0]),
                   64'({fr[1+4*k], fr[2+4*k], fr[3+4*k], fr[4+4*k]}));
      end
   endtask

   // Sends the frame in fr and checks writes and status against the frame rules.
   task automatic run_frame(input bit gaps, input int mid_start_at);
      int         n;
      bit         bad_len;
      bit         good;
      logic [7:0] cs;
      int         c;
      n       = fr[0];
      bad_len = (n == 0) || (n > 16);
      cs      = 8'd0;
      if (!bad_len) for (int i = 1; i <= 4 * n; i++) cs ^= fr[i];
      good    = !bad_len && (fr[4*n+1] == cs);

      wq.delete();
      pulse_start();
      check_val("busy_after_start", 64'(busy), 64'd1);
      check_val("stall_after_start", 64'(core_stall), 64'd1);
      check_val("ready_in_len", 64'(in_ready), 64'd1);
      for (int i = 0; i < fr.size(); i++) begin
         if (i == mid_start_at) pulse_start();
         send_byte(fr[i], gaps);
      end
      c = 0;
      while (!(done || error) && c < 20) begin
         @(negedge clk);
         c++;
      end
      if (c == 20) check_val("status_timeout", 64'd0, 64'd1);
      check_val("done", 64'(done), 64'(good));
      check_val("error", 64'(error), 64'(!good));
      check_val("words_loaded", 64'(words_loaded), bad_len ? 64'd0 : 64'(n));
      check_val("stall_after_end", 64'(core_stall), 64'd0);
      check_writes(bad_len ? 0 : n, 16);
      @(negedge clk);
      check_val("ready_idle", 64'(in_ready), 64'd0);
      check_val("busy_idle", 64'(busy), 64'd0);
   endtask

   task automatic build_rand(input int n, input bit good);
      logic [7:0] cs;
      fr.delete();
      fr.push_back(8'(n));
      if (n == 0 || n > 16) return;
      cs = 8'd0;
      for (int i = 0; i < 4 * n; i++) begin
         fr.push_back(8'($urandom));
         cs ^= fr[$];
      end
      fr.push_back(good ? cs : ~cs);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_ready"}, 64'(in_ready), 64'd0);
      check_val({tag, "_wren"}, 64'(im_wr_en), 64'd0);
      check_val({tag, "_addr"}, im_wr_addr, 64'd0);
      check_val({tag, "_data"}, 64'(im_wr_data), 64'd0);
      check_val({tag, "_stall"}, 64'(core_stall), 64'd0);
      check_val({tag, "_busy"}, 64'(busy), 64'd0);
      check_val({tag, "_done"}, 64'(done), 64'd0);
      check_val({tag, "_error"}, 64'(error), 64'd0);
      check_val({tag, "_words"}, 64'(words_loaded), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      fr = '{8'd2, 8'hF8, 8'h40, 8'h01, 8'h82, 8'hF8, 8'h40, 8'h01, 8'hA3, 8'h21};
      run_frame(1'b0, -1);
      fr[9] = 8'h22;
      run_frame(1'b0, -1);

      fr = '{8'd0};
      run_frame(1'b1, -1);
      fr = '{8'd17};
      run_frame(1'b0, -1);

      fr.delete();
      fr.push_back(8'd16);
      for (int i = 0; i < 64; i++) fr.push_back(8'(i));
      fr.push_back(8'h00);
      run_frame(1'b1, -1);

      // Reset in the middle of an N=4 load, after the sixth payload byte.
      build_rand(4, 1'b1);
      wq.delete();
      pulse_start();
      for (int i = 0; i < 7; i++) send_byte(fr[i], 1'b1);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (3) @(negedge clk);
      check_all_zero("midreset_hold");
      check_writes(1, 1);
      rst_n = 1'b1;
      @(negedge clk);
      build_rand(3, 1'b1);
      run_frame(1'b1, -1);

      // Start pulsed in the middle of DATA must be ignored.
      build_rand(5, 1'b1);
      run_frame(1'b1, 4);
      pulse_start();
      check_val("restart_done", 64'(done), 64'd0);
      check_val("restart_words", 64'(words_loaded), 64'd0);
      send_byte(8'd0, 1'b0);
      check_val("restart_badlen_err", 64'(error), 64'd1);
      @(negedge clk);

      for (int t = 0; t < 8; t++) begin
         int n;
         n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) * 17 : $urandom_range(1, 16);
         build_rand(n, $urandom_range(0, 3) != 0);
         run_frame(1'b1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
